// File: rtl/biss_slave_tx.sv
// biss_slave_tx
//   BiSS-C slave transmitter. Watches the master clock MA and shifts out one
//   frame per MA burst on SLO:
//     Ack (ACK_CLKS clk low) -> Start(1) -> CDS(0) -> 28 data bits -> 6 CRC bits
//   After the last CRC bit SLO is held low until MA has stayed high for
//   TIMEOUT_CLKS clk. The same MA-high timeout aborts an unfinished frame.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ma_in        BiSS-C MA line (asynchronous, idle high)
//   slo_out      BiSS-C SLO line (registered, idle high)
//   pos_in       26-bit position, sampled at frame latch
//   err_n/warn_n active-low status bits, sampled with pos_in
//   busy         high whenever the FSM is not in IDLE
//   frame_latch  one-clk pulse when the payload is sampled
//   frame_done   one-clk pulse when the last CRC bit has completed
//   crc_out      inverted CRC of the most recently latched frame
module biss_slave_tx #(
  parameter int ACK_CLKS     = 8,
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ma_in,
  output logic        slo_out,
  input  logic [25:0] pos_in,
  input  logic        err_n,
  input  logic        warn_n,
  output logic        busy,
  output logic        frame_latch,
  output logic        frame_done,
  output logic [5:0]  crc_out
);

  localparam int ACK_W = (ACK_CLKS > 1) ? $clog2(ACK_CLKS) : 1;
  localparam int HI_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CLKS - 1);
  localparam logic [HI_W-1:0]  HI_MAX   = HI_W'(TIMEOUT_CLKS);
  localparam logic [HI_W-1:0]  HI_EXP   = HI_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARM     = 4'd1,
    S_ACK     = 4'd2,
    S_READY   = 4'd3,
    S_START   = 4'd4,
    S_CDS     = 4'd5,
    S_DATA    = 4'd6,
    S_CRC     = 4'd7,
    S_TIMEOUT = 4'd8
  } state_e;

  // CRC x^6+x+1, init 0, over the 28 payload bits MSB first.
  function automatic logic [5:0] crc6_calc(input logic [27:0] d);
    logic [5:0] c;
    logic       fb;
    c = 6'h00;
    for (int i = 27; i >= 0; i--) begin
      fb = c[5] ^ d[i];
      c  = {c[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic               ma_meta_q, ma_sync_q, ma_prev_q;
  logic [HI_W-1:0]    hi_cnt_q, hi_cnt_d;
  logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic [4:0]         bit_q, bit_d;        // index of the bit currently on SLO
  logic [27:0]        pay_q, pay_d;
  logic [5:0]         crc_q, crc_d;
  logic               slo_q, slo_d;
  logic               busy_q, busy_d;
  logic               latch_q, latch_d;
  logic               done_q, done_d;
  logic               rise_s;
  logic               timeout_s;
  logic [27:0]        payload_s;

  assign rise_s    = ma_sync_q & ~ma_prev_q;
  // Fires in the cycle that completes TIMEOUT_CLKS consecutive high samples
  // (and stays asserted while saturated).
  assign timeout_s = ma_sync_q & (hi_cnt_q >= HI_EXP);
  assign payload_s = {pos_in, err_n, warn_n};

  assign slo_out     = slo_q;
  assign busy        = busy_q;
  assign frame_latch = latch_q;
  assign frame_done  = done_q;
  assign crc_out     = crc_q;

  // State register plus all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ma_meta_q <= 1'b1;
      ma_sync_q <= 1'b1;
      ma_prev_q <= 1'b1;
      hi_cnt_q  <= '0;
      ack_cnt_q <= '0;
      bit_q     <= 5'd0;
      pay_q     <= 28'd0;
      crc_q     <= 6'h00;
      slo_q     <= 1'b1;
      busy_q    <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ma_meta_q <= ma_in;
      ma_sync_q <= ma_meta_q;
      ma_prev_q <= ma_sync_q;
      hi_cnt_q  <= hi_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      bit_q     <= bit_d;
      pay_q     <= pay_d;
      crc_q     <= crc_d;
      slo_q     <= slo_d;
      busy_q    <= busy_d;
      latch_q   <= latch_d;
      done_q    <= done_d;
    end
  end

  // MA-high run-length counter: clears on low, saturates at TIMEOUT_CLKS.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (!ma_sync_q) begin
      hi_cnt_d = '0;
    end else if (hi_cnt_q == HI_MAX) begin
      hi_cnt_d = hi_cnt_q;
    end else begin
      hi_cnt_d = hi_cnt_q + HI_W'(1);
    end
  end

  // Next-state logic; timeout overrides any rise event in the same cycle.
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    bit_d     = bit_q;
    pay_d     = pay_q;
    crc_d     = crc_q;
    if ((state_q != S_IDLE) && timeout_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise_s) begin
            state_d = S_ARM;
            pay_d   = payload_s;
            crc_d   = ~crc6_calc(payload_s);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARM: begin
          if (rise_s) begin
            state_d   = S_ACK;
            ack_cnt_d = '0;
          end else begin
            state_d = S_ARM;
          end
        end
        S_ACK: begin
          if (ack_cnt_q == ACK_LAST) begin
            state_d = S_READY;
          end else begin
            ack_cnt_d = ack_cnt_q + ACK_W'(1);
          end
        end
        S_READY: begin
          if (rise_s) state_d = S_START;
          else        state_d = S_READY;
        end
        S_START: begin
          if (rise_s) state_d = S_CDS;
          else        state_d = S_START;
        end
        S_CDS: begin
          if (rise_s) begin
            state_d = S_DATA;
            bit_d   = 5'd27;
          end else begin
            state_d = S_CDS;
          end
        end
        S_DATA: begin
          if (rise_s && (bit_q == 5'd0)) begin
            state_d = S_CRC;
            bit_d   = 5'd5;
          end else if (rise_s) begin
            bit_d = bit_q - 5'd1;
          end else begin
            bit_d = bit_q;
          end
        end
        S_CRC: begin
          if (rise_s && (bit_q == 5'd0)) begin
            state_d = S_TIMEOUT;
          end else if (rise_s) begin
            bit_d = bit_q - 5'd1;
          end else begin
            bit_d = bit_q;
          end
        end
        S_TIMEOUT: state_d = S_TIMEOUT;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: SLO level is a function of the state being entered.
  always_comb begin
    slo_d   = 1'b1;
    busy_d  = (state_d != S_IDLE);
    latch_d = (state_q == S_IDLE) && (state_d == S_ARM);
    done_d  = (state_q == S_CRC) && (state_d == S_TIMEOUT);
    case (state_d)
      S_IDLE, S_ARM, S_START:             slo_d = 1'b1;
      S_ACK, S_READY, S_CDS, S_TIMEOUT:   slo_d = 1'b0;
      S_DATA:                             slo_d = pay_d[bit_d];
      S_CRC:                              slo_d = crc_d[bit_d[2:0]];
      default:                            slo_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_biss_slave_tx.sv
module tb_biss_slave_tx;

  localparam int ACK_CLKS     = 8;
  localparam int TIMEOUT_CLKS = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ma_in = 1'b1;
  logic        slo_out;
  logic [25:0] pos_in = 26'd0;
  logic        err_n = 1'b0;
  logic        warn_n = 1'b0;
  logic        busy;
  logic        frame_latch;
  logic        frame_done;
  logic [5:0]  crc_out;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_latch = 0;
  int n_done  = 0;
  logic exp_q[$];

  biss_slave_tx #(.ACK_CLKS(ACK_CLKS), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .clk(clk), .rst_n(rst_n), .ma_in(ma_in), .slo_out(slo_out),
    .pos_in(pos_in), .err_n(err_n), .warn_n(warn_n), .busy(busy),
    .frame_latch(frame_latch), .frame_done(frame_done), .crc_out(crc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_latch) n_latch <= n_latch + 1;
    if (frame_done)  n_done  <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference CRC, bit-serial as defined for the link.
  function automatic logic [5:0] ref_crc(input logic [27:0] d);
    logic [5:0] c = 6'h00;
    for (int i = 27; i >= 0; i--) begin
      if (c[5] ^ d[i]) c = {c[4:0], 1'b0} ^ 6'h03;
      else             c = {c[4:0], 1'b0};
    end
    return c;
  endfunction

  // One MA period of 6 clk (3 low, 3 high); returns #1 after the edge on
  // which the DUT reacts to the rise.
  task automatic ma_rise();
    ma_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 ma_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Drives n_rises MA rises of a frame and compares SLO after each rise.
  // With 6-clk MA periods the third rise falls inside the 8-clk Ack and
  // must be ignored; the fourth produces Start.
  task automatic run_frame(input int fid, input logic [25:0] pos, input logic e,
                           input logic w, input int n_rises, input logic change);
    logic [27:0] pay;
    logic [5:0]  crc;
    logic        seq [40];
    logic        expv;
    pay = {pos, e, w};
    crc = ~ref_crc(pay);
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b0; seq[3] = 1'b1; seq[4] = 1'b0;
    for (int k = 0; k < 28; k++) seq[5 + k] = pay[27 - k];
    for (int j = 0; j < 6; j++)  seq[33 + j] = crc[5 - j];
    seq[39] = 1'b0;
    pos_in = pos; err_n = e; warn_n = w;
    for (int i = 0; i < n_rises; i++) begin
      exp_q.push_back(seq[i]);
      ma_rise();
      expv = exp_q.pop_front();
      chk($sformatf("slo f%0d r%0d", fid, i), {31'd0, slo_out}, {31'd0, expv});
      if (i == 0 && change) begin
        pos_in = ~pos; err_n = ~e; warn_n = ~w;
      end
      if (i == 20) chk($sformatf("busy f%0d", fid), {31'd0, busy}, 32'd1);
    end
    if (n_rises >= 4) chk($sformatf("crc_out f%0d", fid), {26'd0, crc_out}, {26'd0, crc});
  endtask

  task automatic hold_high_check(input string tag);
    ma_in = 1'b1;
    repeat (TIMEOUT_CLKS + 5) @(posedge clk);
    #1;
    chk({tag, " slo idle"}, {31'd0, slo_out}, 32'd1);
    chk({tag, " busy idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int l0, d0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst slo", {31'd0, slo_out}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst latch", {31'd0, frame_latch}, 32'd0);
    chk("rst done", {31'd0, frame_done}, 32'd0);
    chk("rst crc", {26'd0, crc_out}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // All-zero frame: CRC 0 inverted -> 3F.
    l0 = n_latch; d0 = n_done;
    run_frame(1, 26'd0, 1'b0, 1'b0, 40, 1'b0);
    chk("f1 crc const", {26'd0, crc_out}, 32'h3F);
    hold_high_check("f1");
    chk("f1 latch count", n_latch - l0, 32'd1);
    chk("f1 done count", n_done - d0, 32'd1);

    // Only warn_n set: CRC 03 inverted -> 3C.
    d0 = n_done;
    run_frame(2, 26'd0, 1'b0, 1'b1, 40, 1'b0);
    chk("f2 crc const", {26'd0, crc_out}, 32'h3C);
    hold_high_check("f2");
    chk("f2 done count", n_done - d0, 32'd1);

    // All ones, inputs changed right after latch must not disturb the frame.
    run_frame(3, 26'h3FFFFFF, 1'b1, 1'b1, 40, 1'b1);
    hold_high_check("f3");

    // Abort mid-DATA by holding MA high.
    d0 = n_done;
    run_frame(4, 26'h2A5A5A5, 1'b1, 1'b0, 20, 1'b0);
    hold_high_check("f4 abort");
    chk("f4 no done", n_done - d0, 32'd0);
    d0 = n_done;
    run_frame(5, 26'h1555555, 1'b0, 1'b1, 40, 1'b0);
    hold_high_check("f5");
    chk("f5 done count", n_done - d0, 32'd1);

    // Reset pulsed during CRC, then a fresh frame.
    d0 = n_done;
    run_frame(6, 26'h0F0F0F0, 1'b1, 1'b1, 36, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid slo", {31'd0, slo_out}, 32'd1);
    chk("rst mid busy", {31'd0, busy}, 32'd0);
    chk("rst mid crc", {26'd0, crc_out}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mid no done", n_done - d0, 32'd0);
    run_frame(7, 26'h3C3A5E1, 1'b0, 1'b1, 40, 1'b0);
    hold_high_check("f7");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/biss_slave_tx.md
BISS_SLAVE_TX -- requirements
Module: biss_slave_tx

Interface
REQ-001 Parameter ACK_CLKS, default 8: clk cycles SLO is held in Ack before the slave is ready (>=1).
REQ-002 Parameter TIMEOUT_CLKS, default 1000: consecutive clk cycles of MA high that end a frame or abort it (>=4).
REQ-003 clk  input  1  single system clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ma_in  input  1  BiSS-C master clock MA, asynchronous to clk, idle high.
REQ-006 slo_out  output  1  BiSS-C slave data line SLO, idle high.
REQ-007 pos_in  input  26  position word, sampled at frame latch.
REQ-008 err_n  input  1  error bit, active-low, sampled with pos_in.
REQ-009 warn_n  input  1  warning bit, active-low, sampled with pos_in.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_latch  output  1  one-clk pulse when the payload is sampled.
REQ-012 frame_done  output  1  one-clk pulse when the last CRC bit has been completed.
REQ-013 crc_out  output  6  transmitted (inverted) CRC of the most recently latched frame.

Function
REQ-014 ma_in SHALL pass through a 2-FF synchronizer; a rise event is synchronized MA high with the previous synchronized value low.
REQ-015 slo_out SHALL be a register updated on the clk edge where the rise event is seen, 3 clk after MA is first sampled high.
REQ-016 The payload SHALL be the 28 bits {pos_in[25:0], err_n, warn_n}, transmitted MSB first (pos_in[25] first, warn_n last).
REQ-017 The CRC SHALL use polynomial x^6+x+1 with init 0, computed over the 28 payload bits MSB first as: fb = c[5]^d; c = {c[4:0],0} ^ (fb ? 6'h03 : 0).
REQ-018 The transmitted CRC SHALL be ~c, MSB first, and SHALL equal crc_out.
REQ-019 crc_out SHALL be valid no later than the transition into START.
REQ-020 States SHALL be IDLE, ARM, ACK, READY, START, CDS, DATA, CRC and TIMEOUT.
REQ-021 IDLE: slo=1; on a rise event go to ARM, sample the payload, pulse frame_latch.
REQ-022 ARM: slo=1; on a rise event go to ACK with slo=0 and clear the ack counter.
REQ-023 ACK: slo=0; rise events are ignored; after ACK_CLKS clk go to READY.
REQ-024 READY: slo=0; on a rise event go to START with slo=1.
REQ-025 START: on a rise event go to CDS with slo=0, since the CDS bit is always 0.
REQ-026 CDS: on a rise event go to DATA with slo = payload bit 27.
REQ-027 DATA: each rise event drives the next lower payload bit; the rise after bit 0 goes to CRC with slo=~c[5].
REQ-028 CRC: each rise event drives the next lower inverted CRC bit.
REQ-029 After the rise following the ~c[0] bit, the block SHALL go to TIMEOUT with slo=0 and pulse frame_done.
REQ-030 TIMEOUT: slo=0; when synchronized MA has been continuously high for TIMEOUT_CLKS clk, go to IDLE with slo=1.
REQ-031 Abort: in any non-IDLE state, synchronized MA continuously high for TIMEOUT_CLKS clk SHALL force IDLE with slo=1 and no frame_done.
REQ-032 The MA-high counter SHALL clear on any synchronized MA low and saturate at TIMEOUT_CLKS.
REQ-033 Changes on pos_in, err_n or warn_n after the latch SHALL NOT affect the frame in progress.
REQ-034 A rise event in the same cycle as timeout expiry SHALL be ignored; timeout takes priority.

Reset
REQ-035 On rst_n low, asynchronously: state=IDLE, slo_out=1, busy=0, frame_latch=0, frame_done=0, crc_out=6'h00, all counters and synchronizer flops cleared to MA-idle (high).
REQ-036 Reset mid-frame SHALL abandon the frame; after release the block waits in IDLE for a fresh rise event.

Verification
REQ-037 pos=0, err_n=0, warn_n=0, full MA burst -> SLO sequence 1,0(ack..),1,0, 28x0, CRC bits 111111; crc_out=6'h3F; frame_done once.
REQ-038 pos=0, err_n=0, warn_n=1 -> last payload bit 1, CRC bits 111100, crc_out=6'h3C.
REQ-039 pos=26'h3FFFFFF, err_n=1, warn_n=1 -> check SLO against a serial model; pos_in changed after frame_latch -> frame unchanged.
REQ-040 MA held high for TIMEOUT_CLKS mid-DATA -> IDLE, slo=1, busy=0, no frame_done; next burst transmits correctly.
REQ-041 Rise events during ACK (ACK_CLKS=8) -> slo stays 0; Start appears only on the first rise after 8 clk.
REQ-042 rst_n pulsed low during CRC -> immediately slo=1, busy=0, crc_out=0; new frame after release is correct.
